escalonador_elevador: RTL and testbench
=======================================

ESCALONADOR_ELEVADOR -- requirements
Module: escalonador_elevador

Interface
REQ-001 Parameter T_PORTA, default 3, door-open dwell in clk cycles (range 1..15).
REQ-002 clk  input  1  one-second tick from the clock divider; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-low (button B3); reset=0 forces reset state immediately.
REQ-004 chamada  input  3  floor call buttons, bit0=floor 1, bit1=floor 2, bit2=floor 3; level, sampled each posedge.
REQ-005 sensor_andar  input  3  one-hot floor sensor, 000 = between floors.
REQ-006 cheio  input  1  1 = car full, departure inhibited.
REQ-007 motor_sobe  output  1  motor up command.
REQ-008 motor_desce  output  1  motor down command.
REQ-009 porta_aberta  output  1  door open command.
REQ-010 pendente  output  3  latched outstanding calls, same bit mapping as chamada.
REQ-011 andar  output  2  last valid floor, 00/01/10 = floors 1/2/3.
REQ-012 estado  output  3  FSM state code; erro  output  1  sensor fault flag.

Function
REQ-013 FSM states SHALL be PARADO=000, SUBINDO=001, DESCENDO=010, PORTA=011, FALHA=100; all outputs SHALL be registered and update on the same edge as estado.
REQ-014 motor_sobe=1 only in SUBINDO, motor_desce=1 only in DESCENDO, porta_aberta=1 only in PORTA; never two at once.
REQ-015 Each posedge: pendente <= pendente | chamada, except the bit of the floor whose door is open in PORTA, which is cleared and not latched.
REQ-016 andar SHALL load the encoded sensor value on every posedge where sensor_andar is exactly one-hot; held when 000.
REQ-017 Direction register dir (1=up) SHALL be kept; "ahead" = pending floors above andar when dir=1, below when dir=0.
REQ-018 PARADO: pendente[andar]=1 -> PORTA; else if cheio=1 -> stay; else pending ahead -> move in dir; else pending opposite -> reverse dir and move; else stay.
REQ-019 SUBINDO/DESCENDO: on sensor showing floor f with pendente[f]=1 -> PORTA, clear pendente[f], load timer with T_PORTA.
REQ-020 SUBINDO at floor 3 or DESCENDO at floor 1 with no call there -> PARADO (end-of-travel stop); cheio SHALL NOT stop a moving car.
REQ-021 PORTA: 4-bit timer decrements each cycle; cheio=1 or chamada[andar]=1 reloads T_PORTA; at timer=0 apply REQ-018 decision excluding the PORTA branch.
REQ-022 Decision latency: a call for another floor latched at edge N SHALL produce motor output at edge N+1 from PARADO.
REQ-023 sensor_andar with two or more bits set in any state -> FALHA: motors off, door closed, erro=1, calls still latched; exit only via reset.
REQ-024 Call and service for the same floor on the same edge: service wins, bit cleared.

Reset
REQ-025 reset=0 SHALL asynchronously set estado=PARADO, dir=1, pendente=000, andar=00, timer=0, erro=0, all motor/door outputs 0.
REQ-026 reset asserted mid-travel SHALL drop motors within the same cycle; after release the FSM resumes from PARADO with andar from the next valid sensor reading.
REQ-027 No output SHALL glitch on reset release; first state change occurs on the first posedge with reset=1.

Verification
REQ-028 Idle at floor 1, chamada=100 one cycle -> pendente=100, next edge motor_sobe=1; sensor 010 passes (no stop); sensor 100 -> PORTA, porta_aberta=1 for 3 cycles, pendente=000, then PARADO.
REQ-029 At floor 2 going up, calls 100 and 001 latched -> serves floor 3 first, then reverses, dir=0, serves floor 1.
REQ-030 PORTA with cheio=1 held 10 cycles -> porta_aberta stays 1, no motor; cheio=0 -> closes after exactly T_PORTA cycles.
REQ-031 Door open at floor 2, chamada=010 -> timer reloads, pendente[1] stays 0.
REQ-032 sensor_andar=011 while SUBINDO -> estado=FALHA, erro=1, motors 0; reset pulse -> PARADO, erro=0.
REQ-033 reset=0 asserted between clock edges during DESCENDO -> motor_desce=0 immediately, pendente=000.

Source files
------------

// File: rtl/escalonador_elevador_if.sv
// Call, sensor and command bundle of the three-floor elevator scheduler.
// The slave side is the scheduler; the master side is whatever drives the car.
interface escalonador_elevador_if;
  logic [2:0] chamada;
  logic [2:0] sensor_andar;
  logic       cheio;
  logic       motor_sobe;
  logic       motor_desce;
  logic       porta_aberta;
  logic [2:0] pendente;
  logic [1:0] andar;
  logic [2:0] estado;
  logic       erro;

  modport slave (
    input  chamada, sensor_andar, cheio,
    output motor_sobe, motor_desce, porta_aberta, pendente, andar, estado, erro
  );

  modport master (
    output chamada, sensor_andar, cheio,
    input  motor_sobe, motor_desce, porta_aberta, pendente, andar, estado, erro
  );
endinterface

// File: rtl/escalonador_elevador.sv
// Three-floor elevator scheduler: latches calls, sweeps in the current direction,
// holds the door for T_PORTA ticks and locks into FALHA on an impossible sensor reading.
module escalonador_elevador #(
  parameter int T_PORTA = 3
) (
  input logic                  clk,
  input logic                  reset,
  escalonador_elevador_if.slave io
);

  typedef enum logic [2:0] {
    PARADO   = 3'b000,
    SUBINDO  = 3'b001,
    DESCENDO = 3'b010,
    PORTA    = 3'b011,
    FALHA    = 3'b100
  } estado_t;

  localparam logic [3:0] T_LD = 4'(T_PORTA);

  estado_t    estado_q, estado_d;
  logic       dir_q, dir_d;
  logic [2:0] pendente_q, pendente_d;
  logic [1:0] andar_q, andar_d;
  logic [3:0] timer_q, timer_d;
  logic       motor_sobe_q, motor_sobe_d;
  logic       motor_desce_q, motor_desce_d;
  logic       porta_q, porta_d;
  logic       erro_q, erro_d;

  logic [2:0] sens;
  logic       fault, onehot;
  logic [1:0] sens_floor;
  logic [2:0] sens_mask, andar_mask, pend_latch, pend_dec;
  logic       above, below, want_up, want_down;

  assign sens       = io.sensor_andar;
  assign fault      = (sens[0] & sens[1]) | (sens[0] & sens[2]) | (sens[1] & sens[2]);
  assign onehot     = (sens != 3'b000) && !fault;
  assign sens_floor = sens[2] ? 2'd2 : (sens[1] ? 2'd1 : 2'd0);
  assign sens_mask  = sens;
  assign andar_mask = 3'b001 << andar_q;
  assign pend_latch = pendente_q | io.chamada;

  // The floor the car stands at never counts as "ahead" or "behind".
  assign pend_dec  = pendente_q & ~andar_mask;
  assign above     = (andar_q == 2'd0) ? (pend_dec[1] | pend_dec[2]) :
                     (andar_q == 2'd1) ? pend_dec[2] : 1'b0;
  assign below     = (andar_q == 2'd2) ? (pend_dec[0] | pend_dec[1]) :
                     (andar_q == 2'd1) ? pend_dec[0] : 1'b0;
  assign want_up   = dir_q ? above : (above & ~below);
  assign want_down = dir_q ? (below & ~above) : below;

  always_comb begin
    estado_d   = estado_q;
    dir_d      = dir_q;
    timer_d    = timer_q;
    pendente_d = pend_latch;
    andar_d    = onehot ? sens_floor : andar_q;

    if (fault) begin
      estado_d = FALHA;
    end else begin
      unique case (estado_q)
        PARADO: begin
          if ((pendente_q & andar_mask) != 3'b000) begin
            estado_d   = PORTA;
            timer_d    = T_LD;
            pendente_d = pend_latch & ~andar_mask;
          end else if (!io.cheio) begin
            if (want_up) begin
              estado_d = SUBINDO;
              dir_d    = 1'b1;
            end else if (want_down) begin
              estado_d = DESCENDO;
              dir_d    = 1'b0;
            end
          end
        end
        SUBINDO, DESCENDO: begin
          if (onehot && (pendente_q & sens_mask) != 3'b000) begin
            estado_d   = PORTA;
            timer_d    = T_LD;
            pendente_d = pend_latch & ~sens_mask;
          end else if ((estado_q == SUBINDO && sens == 3'b100) ||
                       (estado_q == DESCENDO && sens == 3'b001)) begin
            estado_d = PARADO;
          end
        end
        PORTA: begin
          pendente_d = pend_latch & ~andar_mask;
          if (io.cheio || (io.chamada & andar_mask) != 3'b000) begin
            timer_d = T_LD;
          end else if (timer_q <= 4'd1) begin
            // Door closes on the edge the count reaches zero; pick the next move now.
            timer_d  = 4'd0;
            estado_d = PARADO;
            if (want_up) begin
              estado_d = SUBINDO;
              dir_d    = 1'b1;
            end else if (want_down) begin
              estado_d = DESCENDO;
              dir_d    = 1'b0;
            end
          end else begin
            timer_d = timer_q - 4'd1;
          end
        end
        default: estado_d = FALHA;
      endcase
    end

    motor_sobe_d  = (estado_d == SUBINDO);
    motor_desce_d = (estado_d == DESCENDO);
    porta_d       = (estado_d == PORTA);
    erro_d        = (estado_d == FALHA);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado_q      <= PARADO;
      dir_q         <= 1'b1;
      pendente_q    <= 3'b000;
      andar_q       <= 2'b00;
      timer_q       <= 4'd0;
      motor_sobe_q  <= 1'b0;
      motor_desce_q <= 1'b0;
      porta_q       <= 1'b0;
      erro_q        <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      dir_q         <= dir_d;
      pendente_q    <= pendente_d;
      andar_q       <= andar_d;
      timer_q       <= timer_d;
      motor_sobe_q  <= motor_sobe_d;
      motor_desce_q <= motor_desce_d;
      porta_q       <= porta_d;
      erro_q        <= erro_d;
    end
  end

  assign io.estado       = estado_q;
  assign io.motor_sobe   = motor_sobe_q;
  assign io.motor_desce  = motor_desce_q;
  assign io.porta_aberta = porta_q;
  assign io.pendente     = pendente_q;
  assign io.andar        = andar_q;
  assign io.erro         = erro_q;

endmodule

// File: tb/tb_escalonador_elevador.sv
// Directed scenarios plus a random soak for escalonador_elevador, all checked
// cycle by cycle against a floor/queue-level model of the elevator rules.
module tb_escalonador_elevador;
  localparam int TP = 3;
  localparam int S_PARADO = 0, S_SOBE = 1, S_DESCE = 2, S_PORTA = 3, S_FALHA = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  escalonador_elevador_if io();
  escalonador_elevador #(.T_PORTA(TP)) dut (.clk(clk), .reset(reset), .io(io));

  int n_cmp = 0;
  int n_bad = 0;

  // model: state as plain integers, floors numbered 0..2
  int         m_st, m_floor, m_door;
  bit         m_dir;
  logic [2:0] m_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] dut_vec();
    return {io.estado, io.motor_sobe, io.motor_desce, io.porta_aberta,
            io.pendente, io.andar, io.erro};
  endfunction

  function automatic logic [11:0] mdl_vec();
    return {3'(m_st), m_st == S_SOBE, m_st == S_DESCE, m_st == S_PORTA,
            m_pend, 2'(m_floor), m_st == S_FALHA};
  endfunction

  task automatic m_reset();
    m_st = S_PARADO; m_floor = 0; m_door = 0; m_dir = 1'b1; m_pend = 3'b000;
  endtask

  task automatic m_decide(input int f, input logic [2:0] p);
    bit up_calls = 0, down_calls = 0;
    for (int k = f + 1; k < 3; k++) if (p[k]) up_calls = 1;
    for (int k = 0; k < f; k++) if (p[k]) down_calls = 1;
    m_st = S_PARADO;
    if (m_dir) begin
      if (up_calls) m_st = S_SOBE;
      else if (down_calls) begin m_st = S_DESCE; m_dir = 1'b0; end
    end else begin
      if (down_calls) m_st = S_DESCE;
      else if (up_calls) begin m_st = S_SOBE; m_dir = 1'b1; end
    end
  endtask

  task automatic m_step(input logic [2:0] ch, input logic [2:0] s, input logic full);
    int nb = int'(s[0]) + int'(s[1]) + int'(s[2]);
    int sf = -1;
    logic [2:0] old = m_pend;
    logic [2:0] p_in = m_pend | ch;
    logic [2:0] one = 3'b001;
    if (nb == 1) sf = s[0] ? 0 : (s[1] ? 1 : 2);
    if (nb >= 2 || m_st == S_FALHA) begin
      m_st = S_FALHA;
      m_pend = p_in;
    end else begin
      case (m_st)
        S_PARADO: begin
          if (old[m_floor]) begin
            m_st = S_PORTA; m_door = TP; m_pend = p_in & ~(one << m_floor);
          end else begin
            m_pend = p_in;
            if (!full) m_decide(m_floor, old);
          end
        end
        S_SOBE, S_DESCE: begin
          if (sf >= 0 && old[sf]) begin
            m_st = S_PORTA; m_door = TP; m_pend = p_in & ~(one << sf);
          end else begin
            m_pend = p_in;
            if (m_st == S_SOBE && sf == 2) m_st = S_PARADO;
            if (m_st == S_DESCE && sf == 0) m_st = S_PARADO;
          end
        end
        default: begin
          m_pend = p_in & ~(one << m_floor);
          if (full || ch[m_floor]) m_door = TP;
          else begin
            m_door--;
            if (m_door == 0) m_decide(m_floor, old & ~(one << m_floor));
          end
        end
      endcase
    end
    if (sf >= 0) m_floor = sf;
  endtask

  task automatic tick(input logic [2:0] ch, input logic [2:0] s, input logic full);
    io.chamada = ch; io.sensor_andar = s; io.cheio = full;
    @(posedge clk);
    m_step(ch, s, full);
    #1;
    chk("cycle_outputs", dut_vec(), mdl_vec());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    chk("reset_state", dut_vec(), 12'b0);
    m_reset();
    #2;
    reset = 1'b1;
  endtask

  initial begin
    io.chamada = 3'b000; io.sensor_andar = 3'b001; io.cheio = 1'b0;
    m_reset();
    #1;
    do_reset();

    // single call to floor 3 from floor 1, passing floor 2
    tick(3'b000, 3'b001, 0);
    tick(3'b100, 3'b001, 0); chk("call_latched", io.pendente, 3'b100);
    tick(3'b000, 3'b001, 0); chk("motor_up_next_edge", io.motor_sobe, 1);
    tick(3'b000, 3'b000, 0);
    tick(3'b000, 3'b010, 0); chk("pass_floor2", io.estado, S_SOBE);
    tick(3'b000, 3'b000, 0);
    tick(3'b000, 3'b100, 0); chk("arrive_door", io.porta_aberta, 1);
    chk("arrive_cleared", io.pendente, 3'b000);
    tick(3'b000, 3'b100, 0); chk("door_c2", io.porta_aberta, 1);
    tick(3'b000, 3'b100, 0); chk("door_c3", io.porta_aberta, 1);
    tick(3'b000, 3'b100, 0); chk("door_closed", {io.estado, io.porta_aberta}, 4'b0000);

    // sweep up to floor 3 before reversing to floor 1
    do_reset();
    tick(3'b000, 3'b001, 0);
    tick(3'b010, 3'b001, 0);
    tick(3'b000, 3'b001, 0);
    tick(3'b000, 3'b010, 0); chk("stop_floor2", io.estado, S_PORTA);
    tick(3'b101, 3'b010, 0);
    tick(3'b000, 3'b010, 0);
    tick(3'b000, 3'b010, 0); chk("sweep_up_first", io.estado, S_SOBE);
    tick(3'b000, 3'b000, 0);
    tick(3'b000, 3'b100, 0); chk("floor3_served", io.pendente, 3'b001);
    tick(3'b000, 3'b100, 0);
    tick(3'b000, 3'b100, 0);
    tick(3'b000, 3'b100, 0); chk("reverse_down", io.motor_desce, 1);
    tick(3'b000, 3'b010, 0);
    tick(3'b000, 3'b001, 0); chk("floor1_served", {io.porta_aberta, io.pendente}, 4'b1000);

    // full car holds the door, then exactly TP ticks to close
    for (int i = 0; i < 10; i++) begin
      tick(3'b000, 3'b001, 1);
      chk("full_holds", {io.porta_aberta, io.motor_sobe, io.motor_desce}, 3'b100);
    end
    tick(3'b000, 3'b001, 0);
    tick(3'b000, 3'b001, 0); chk("full_release_open", io.porta_aberta, 1);
    tick(3'b000, 3'b001, 0); chk("full_release_close", io.porta_aberta, 0);

    // call for the open-door floor reloads the timer and is not latched
    tick(3'b010, 3'b001, 0);
    tick(3'b000, 3'b001, 0);
    tick(3'b000, 3'b010, 0);
    tick(3'b010, 3'b010, 0); chk("same_floor_call", {io.porta_aberta, io.pendente[1]}, 2'b10);
    tick(3'b000, 3'b010, 0);
    tick(3'b000, 3'b010, 0); chk("reload_open", io.porta_aberta, 1);
    tick(3'b000, 3'b010, 0); chk("reload_close", io.estado, S_PARADO);

    // two sensor bits while moving -> locked fault
    tick(3'b100, 3'b010, 0);
    tick(3'b000, 3'b010, 0); chk("fault_pre_move", io.motor_sobe, 1);
    tick(3'b000, 3'b011, 0);
    chk("fault_state", {io.estado, io.erro, io.motor_sobe, io.motor_desce}, {3'(S_FALHA), 3'b100});
    tick(3'b001, 3'b000, 0); chk("fault_calls_latch", io.pendente, 3'b101);
    do_reset();

    // asynchronous reset between edges while descending
    tick(3'b000, 3'b100, 0);
    tick(3'b001, 3'b100, 0);
    tick(3'b000, 3'b100, 0); chk("descending", io.motor_desce, 1);
    #3 reset = 1'b0;
    #1 chk("async_drop", {io.motor_desce, io.pendente}, 4'b0000);
    m_reset();
    #2 reset = 1'b1;

    // random soak against the model
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] s, ch;
      logic full;
      int r;
      if ($urandom_range(0, 99) == 0) do_reset();
      r = $urandom_range(0, 499);
      if (r == 0) begin
        case ($urandom_range(0, 3))
          0: s = 3'b011;
          1: s = 3'b101;
          2: s = 3'b110;
          default: s = 3'b111;
        endcase
      end else if (r < 200) s = 3'b000;
      else s = 3'b001 << $urandom_range(0, 2);
      ch = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(0, 7)) : 3'b000;
      full = ($urandom_range(0, 9) == 0);
      tick(ch, s, full);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
